// File: rtl/rx_frame_controller_if.sv
// Bundles the demodulator bit stream and the host control/status bits of the
// frame receiver. The controller takes the slave view and the host side takes the master view.
interface rx_frame_controller_if;
  logic       rxenable;
  logic       intmask;
  logic       intflag_clr;
  logic       bit_valid;
  logic       bit_value;
  logic       demod_enable;
  logic       demod_clear;
  logic [7:0] DATA_BYTE_0;
  logic [7:0] DATA_BYTE_1;
  logic       status;
  logic       intflag;
  logic       overrun;
  logic       frame_err;
  logic       int_rx_host;

  modport slave (
    input  rxenable, intmask, intflag_clr, bit_valid, bit_value,
    output demod_enable, demod_clear, DATA_BYTE_0, DATA_BYTE_1,
           status, intflag, overrun, frame_err, int_rx_host
  );

  modport master (
    output rxenable, intmask, intflag_clr, bit_valid, bit_value,
    input  demod_enable, demod_clear, DATA_BYTE_0, DATA_BYTE_1,
           status, intflag, overrun, frame_err, int_rx_host
  );
endinterface

// File: rtl/rx_frame_controller.sv
// Receive frame controller: hunts for a sync word in the demodulated bit stream,
// then captures a two-byte payload and raises a sticky frame-complete interrupt.
module rx_frame_controller #(
  parameter logic [7:0] SYNC_WORD = 8'hA5,
  parameter logic [7:0] TIMEOUT   = 8'd200
) (
  input  logic                        G_CLK_RX,
  input  logic                        reset,
  rx_frame_controller_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HUNT    = 2'd1,
    RECV_B0 = 2'd2,
    RECV_B1 = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] shift_reg;
  logic [7:0] held_byte;
  logic [7:0] gap_cnt;
  logic [7:0] data_byte_0;
  logic [7:0] data_byte_1;
  logic [2:0] bit_cnt;
  logic       demod_clear_q;
  logic       intflag_q;
  logic       overrun_q;
  logic       frame_err_q;

  logic [7:0] shift_next;
  logic       in_frame;
  logic       timed_out;
  logic       byte_done;
  logic       sync_hit;
  logic       frame_done;
  logic       abort;

  assign shift_next = {shift_reg[6:0], bus.bit_value};
  assign in_frame   = (state == RECV_B0) || (state == RECV_B1);
  assign timed_out  = in_frame && (gap_cnt >= TIMEOUT);
  assign byte_done  = in_frame && bus.bit_valid && (bit_cnt == 3'd7);

  always_ff @(posedge G_CLK_RX) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping rxenable wins over everything, then the inter-bit timeout, then data.
  always_comb begin
    state_next = state;
    sync_hit   = 1'b0;
    frame_done = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rxenable) begin
          state_next = HUNT;
        end
      end
      HUNT: begin
        if (!bus.rxenable) begin
          state_next = IDLE;
        end else if (bus.bit_valid && (shift_next == SYNC_WORD)) begin
          state_next = RECV_B0;
          sync_hit   = 1'b1;
        end
      end
      RECV_B0: begin
        if (!bus.rxenable) begin
          state_next = IDLE;
        end else if (timed_out) begin
          state_next = HUNT;
          abort      = 1'b1;
        end else if (byte_done) begin
          state_next = RECV_B1;
        end
      end
      RECV_B1: begin
        if (!bus.rxenable) begin
          state_next = IDLE;
        end else if (timed_out) begin
          state_next = HUNT;
          abort      = 1'b1;
        end else if (byte_done) begin
          state_next = HUNT;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge G_CLK_RX) begin
    if (reset) begin
      shift_reg     <= 8'h00;
      held_byte     <= 8'h00;
      gap_cnt       <= 8'h00;
      bit_cnt       <= 3'd0;
      data_byte_0   <= 8'h00;
      data_byte_1   <= 8'h00;
      demod_clear_q <= 1'b0;
      intflag_q     <= 1'b0;
      overrun_q     <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      demod_clear_q <= (state == IDLE) && bus.rxenable;
      frame_err_q   <= abort;

      // Every road back into HUNT (or a fresh sync) starts from an empty shifter.
      if ((state == IDLE) || abort || frame_done || sync_hit) begin
        shift_reg <= 8'h00;
        bit_cnt   <= 3'd0;
      end else if (bus.bit_valid && (state_next != IDLE)) begin
        shift_reg <= shift_next;
        if (in_frame) begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end

      if ((state == RECV_B0) && (state_next == RECV_B1)) begin
        held_byte <= shift_next;
      end

      if (!in_frame || bus.bit_valid) begin
        gap_cnt <= 8'h00;
      end else if (gap_cnt != 8'hFF) begin
        gap_cnt <= gap_cnt + 8'd1;
      end

      if (frame_done) begin
        data_byte_0 <= held_byte;
        data_byte_1 <= shift_next;
      end

      // A completion in the same cycle as a clear keeps the flag and leaves overrun alone.
      if (frame_done) begin
        intflag_q <= 1'b1;
        if (intflag_q && !bus.intflag_clr) begin
          overrun_q <= 1'b1;
        end
      end else if (bus.intflag_clr) begin
        intflag_q <= 1'b0;
        overrun_q <= 1'b0;
      end
    end
  end

  assign bus.demod_enable = (state != IDLE);
  assign bus.demod_clear  = demod_clear_q;
  assign bus.DATA_BYTE_0  = data_byte_0;
  assign bus.DATA_BYTE_1  = data_byte_1;
  assign bus.status       = in_frame;
  assign bus.intflag      = intflag_q;
  assign bus.overrun      = overrun_q;
  assign bus.frame_err    = frame_err_q;
  assign bus.int_rx_host  = intflag_q & bus.intmask;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Self-checking bench for rx_frame_controller: table vectors, directed frame
// scenarios and a randomized stream compared against a bit-queue reference model.
module tb_rx_frame_controller;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         TOUT = 200;

  logic G_CLK_RX = 1'b0;
  logic reset    = 1'b0;

  always #5 G_CLK_RX = ~G_CLK_RX;

  rx_frame_controller_if bus ();

  rx_frame_controller #(
    .SYNC_WORD (SYNC),
    .TIMEOUT   (8'(TOUT))
  ) dut (
    .G_CLK_RX (G_CLK_RX),
    .reset    (reset),
    .bus      (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: mode 0 = off, 1 = searching for sync, 2 = collecting payload.
  int         m_mode      = 0;
  int         m_window    = 0;
  int         m_hunt_bits = 0;
  int         m_idle      = 0;
  bit         m_payload[$];
  logic [7:0] m_d0  = 8'h00;
  logic [7:0] m_d1  = 8'h00;
  logic       m_flag = 1'b0;
  logic       m_ovr  = 1'b0;
  logic       m_err  = 1'b0;
  logic       m_clr  = 1'b0;

  task automatic stepModel(input logic rst, input logic rxen, input logic bv,
                           input logic bval, input logic clr);
    bit          done;
    logic [15:0] word;
    done = 1'b0;
    word = 16'h0000;
    if (rst) begin
      m_mode = 0; m_window = 0; m_hunt_bits = 0; m_idle = 0;
      m_payload.delete();
      m_d0 = 8'h00; m_d1 = 8'h00;
      m_flag = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_clr = 1'b0;
    end else begin
      m_clr = (m_mode == 0) && rxen;
      m_err = 1'b0;
      if (m_mode == 0) begin
        if (rxen) begin
          m_mode = 1; m_window = 0; m_hunt_bits = 0;
        end
      end else if (!rxen) begin
        m_mode = 0;
      end else if (m_mode == 1) begin
        if (bv) begin
          m_window = (m_window * 2 + int'(bval)) % 256;
          m_hunt_bits++;
          if (m_hunt_bits >= 8 && m_window == int'(SYNC)) begin
            m_mode = 2; m_idle = 0;
            m_payload.delete();
          end
        end
      end else begin
        if (m_idle >= TOUT) begin
          m_err = 1'b1;
          m_mode = 1; m_window = 0; m_hunt_bits = 0;
        end else if (bv) begin
          m_payload.push_back(bval);
          m_idle = 0;
          if (m_payload.size() == 16) begin
            foreach (m_payload[i]) word = word * 16'd2 + 16'(m_payload[i]);
            done = 1'b1;
            m_mode = 1; m_window = 0; m_hunt_bits = 0;
          end
        end else begin
          m_idle++;
        end
      end
      if (done) begin
        if (m_flag && !clr) m_ovr = 1'b1;
        m_flag = 1'b1;
        m_d0 = word[15:8];
        m_d1 = word[7:0];
      end else if (clr) begin
        m_flag = 1'b0;
        m_ovr  = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic checkModel();
    checkOutput("model demod_enable", 8'(bus.demod_enable), 8'(m_mode != 0));
    checkOutput("model demod_clear",  8'(bus.demod_clear),  8'(m_clr));
    checkOutput("model status",       8'(bus.status),       8'(m_mode == 2));
    checkOutput("model DATA_BYTE_0",  bus.DATA_BYTE_0,      m_d0);
    checkOutput("model DATA_BYTE_1",  bus.DATA_BYTE_1,      m_d1);
    checkOutput("model intflag",      8'(bus.intflag),      8'(m_flag));
    checkOutput("model overrun",      8'(bus.overrun),      8'(m_ovr));
    checkOutput("model frame_err",    8'(bus.frame_err),    8'(m_err));
    checkOutput("model int_rx_host",  8'(bus.int_rx_host),  8'(m_flag & bus.intmask));
  endtask

  // Drive one clock cycle, advance the model by the same edge, then compare.
  task automatic applyStimulus(input logic rst, input logic rxen, input logic bv,
                               input logic bval, input logic clr);
    reset           = rst;
    bus.rxenable    = rxen;
    bus.bit_valid   = bv;
    bus.bit_value   = bval;
    bus.intflag_clr = clr;
    @(posedge G_CLK_RX);
    stepModel(rst, rxen, bv, bval, clr);
    #1;
    reset           = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.intflag_clr = 1'b0;
    checkModel();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, bus.rxenable, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
  endtask

  task automatic randBit(input logic b);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 5) == 0));
    applyStimulus(1'b0, 1'b1, 1'b1, b, 1'($urandom_range(0, 5) == 0));
  endtask

  typedef struct {
    logic rst;
    logic rxen;
    logic bv;
    logic bval;
    logic exp_de;
    logic exp_dc;
    logic exp_status;
    logic exp_err;
  } vec_t;

  vec_t table_v[8];

  initial begin
    logic [7:0]  sw;
    logic [15:0] payload;
    int          sel;
    int          brk;
    int          noise;

    bus.rxenable    = 1'b0;
    bus.intmask     = 1'b0;
    bus.intflag_clr = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.bit_value   = 1'b0;

    //            rst   rxen  bv    bval  de    dc    stat  err
    table_v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    table_v[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    table_v[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    table_v[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    table_v[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int v = 0; v < 8; v++) begin
      applyStimulus(table_v[v].rst, table_v[v].rxen, table_v[v].bv, table_v[v].bval, 1'b0);
      checkOutput("table demod_enable", 8'(bus.demod_enable), 8'(table_v[v].exp_de));
      checkOutput("table demod_clear",  8'(bus.demod_clear),  8'(table_v[v].exp_dc));
      checkOutput("table status",       8'(bus.status),       8'(table_v[v].exp_status));
      checkOutput("table frame_err",    8'(bus.frame_err),    8'(table_v[v].exp_err));
    end

    $display("[TB] directed frame scenarios");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset DATA_BYTE_0", bus.DATA_BYTE_0, 8'h00);
    checkOutput("reset intflag", 8'(bus.intflag), 8'h00);
    bus.intmask = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    sendByte(8'hA5);
    checkOutput("after sync status", 8'(bus.status), 8'h01);
    sendByte(8'h3C);
    for (int i = 7; i >= 1; i--) sendBit(1'(8'hC3 >> i));
    checkOutput("before last bit int_rx_host", 8'(bus.int_rx_host), 8'h00);
    sendBit(1'b1);
    checkOutput("frame1 DATA_BYTE_0", bus.DATA_BYTE_0, 8'h3C);
    checkOutput("frame1 DATA_BYTE_1", bus.DATA_BYTE_1, 8'hC3);
    checkOutput("frame1 intflag", 8'(bus.intflag), 8'h01);
    checkOutput("frame1 int_rx_host", 8'(bus.int_rx_host), 8'h01);
    checkOutput("frame1 overrun", 8'(bus.overrun), 8'h00);
    checkOutput("frame1 status", 8'(bus.status), 8'h00);

    sendByte(8'hA5); sendByte(8'h11); sendByte(8'h22);
    checkOutput("frame2 DATA_BYTE_0", bus.DATA_BYTE_0, 8'h11);
    checkOutput("frame2 DATA_BYTE_1", bus.DATA_BYTE_1, 8'h22);
    checkOutput("frame2 overrun", 8'(bus.overrun), 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("clear intflag", 8'(bus.intflag), 8'h00);
    checkOutput("clear overrun", 8'(bus.overrun), 8'h00);

    sendByte(8'hA5); sendByte(8'hF0);
    idleCycles(TOUT);
    checkOutput("gap at limit frame_err", 8'(bus.frame_err), 8'h00);
    checkOutput("gap at limit status", 8'(bus.status), 8'h01);
    idleCycles(1);
    checkOutput("timeout frame_err", 8'(bus.frame_err), 8'h01);
    checkOutput("timeout status", 8'(bus.status), 8'h00);
    checkOutput("timeout demod_enable", 8'(bus.demod_enable), 8'h01);
    checkOutput("timeout DATA_BYTE_0", bus.DATA_BYTE_0, 8'h11);
    checkOutput("timeout DATA_BYTE_1", bus.DATA_BYTE_1, 8'h22);
    idleCycles(1);
    checkOutput("timeout pulse width", 8'(bus.frame_err), 8'h00);

    sendByte(8'hA5); sendByte(8'h44);
    sendBit(1'b0); sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("disable demod_enable", 8'(bus.demod_enable), 8'h00);
    checkOutput("disable status", 8'(bus.status), 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reenable demod_clear", 8'(bus.demod_clear), 8'h01);
    idleCycles(1);
    checkOutput("reenable clear width", 8'(bus.demod_clear), 8'h00);
    sendByte(8'hA5); sendByte(8'h5A); sendByte(8'h69);
    checkOutput("frame3 DATA_BYTE_0", bus.DATA_BYTE_0, 8'h5A);
    checkOutput("frame3 DATA_BYTE_1", bus.DATA_BYTE_1, 8'h69);
    checkOutput("frame3 overrun", 8'(bus.overrun), 8'h00);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.intmask = 1'b0;
    sendByte(8'h52);
    checkOutput("offset no early sync", 8'(bus.status), 8'h00);
    sendBit(1'b1);
    checkOutput("offset sync on ninth bit", 8'(bus.status), 8'h01);
    sendByte(8'h12); sendByte(8'h34);
    checkOutput("offset DATA_BYTE_0", bus.DATA_BYTE_0, 8'h12);
    checkOutput("offset DATA_BYTE_1", bus.DATA_BYTE_1, 8'h34);
    checkOutput("masked intflag", 8'(bus.intflag), 8'h01);
    checkOutput("masked int_rx_host", 8'(bus.int_rx_host), 8'h00);

    sendByte(8'hA5); sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("midframe reset status", 8'(bus.status), 8'h00);
    checkOutput("midframe reset demod_enable", 8'(bus.demod_enable), 8'h00);
    checkOutput("midframe reset intflag", 8'(bus.intflag), 8'h00);
    checkOutput("midframe reset DATA_BYTE_0", bus.DATA_BYTE_0, 8'h00);
    checkOutput("midframe reset DATA_BYTE_1", bus.DATA_BYTE_1, 8'h00);

    $display("[TB] randomized stream");
    sw = SYNC;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 80; f++) begin
      bus.intmask = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        idleCycles(0);
        for (int i = 0; i < int'($urandom_range(1, 3)); i++)
          applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      noise = $urandom_range(0, 4);
      for (int i = 0; i < noise; i++) randBit(1'($urandom_range(0, 1)));
      for (int i = 7; i >= 0; i--) randBit(sw[i]);
      payload = 16'($urandom);
      brk = (sel == 1 || sel == 2) ? int'($urandom_range(0, 15)) : 99;
      for (int k = 0; k < 16; k++) begin
        if (k == brk && sel == 1) idleCycles(TOUT - 1 + int'($urandom_range(0, 2)));
        if (k == brk && sel == 2) begin
          applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
          applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        randBit(payload[15 - k]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
